// File: rtl/regfile_read_port.sv
// Two-operand register-file read port feeding a 2-entry in-order response queue.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data into the operands.
module regfile_read_port #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32,
  parameter int TAGW  = 4
) (
  input  logic                  Clk,
  input  logic                  Clrn,
  input  logic [NREG*WIDTH-1:0] Qbus,
  input  logic                  Wen,
  input  logic [4:0]            Wn,
  input  logic [WIDTH-1:0]      Wd,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            Rna,
  input  logic [4:0]            Rnb,
  input  logic [TAGW-1:0]       req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      Qa,
  output logic [WIDTH-1:0]      Qb,
  output logic [TAGW-1:0]       rsp_tag
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic wr_ptr_reg, rd_ptr_reg;
  logic req_ready_reg, rsp_valid_reg;
  logic push, pop;

  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] opa_next, opb_next;

  logic [WIDTH-1:0] ent_a_reg   [2];
  logic [WIDTH-1:0] ent_b_reg   [2];
  logic [TAGW-1:0]  ent_tag_reg [2];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_unpack
      assign regs[gi] = Qbus[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Register 0 wins over forwarding so a write to r0 can never leak through.
  always_comb begin
    opa_next = regs[Rna];
    opb_next = regs[Rnb];
`ifdef REGFILE_BYPASS_EN
    if (Wen && (Wn == Rna)) opa_next = Wd;
    if (Wen && (Wn == Rnb)) opb_next = Wd;
`endif
    if (Rna == 5'd0) opa_next = '0;
    if (Rnb == 5'd0) opb_next = '0;
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_write;
  assign unused_write = ^{Wen, Wn, Wd};
`endif

  assign push = req_valid && req_ready_reg;
  assign pop  = rsp_valid_reg && rsp_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Handshake flags are registered from the next occupancy, so req_ready
  // never has a combinational path from rsp_ready.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_reg     <= EMPTY;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      req_ready_reg <= (state_next != FULL);
      rsp_valid_reg <= (state_next != EMPTY);
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
          ent_a_reg[gi]   <= '0;
          ent_b_reg[gi]   <= '0;
          ent_tag_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          ent_a_reg[gi]   <= opa_next;
          ent_b_reg[gi]   <= opb_next;
          ent_tag_reg[gi] <= req_tag;
        end
      end
    end
  endgenerate

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign Qa        = ent_a_reg[rd_ptr_reg];
  assign Qb        = ent_b_reg[rd_ptr_reg];
  assign rsp_tag   = ent_tag_reg[rd_ptr_reg];

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port: queue-based reference model checked every
// cycle, plus literal expectations from the test plan.
module tb_regfile_read_port;

  logic          Clk = 1'b0;
  logic          Clrn = 1'b1;
  logic [1023:0] Qbus = '0;
  logic          Wen = 1'b0;
  logic [4:0]    Wn = '0;
  logic [31:0]   Wd = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [4:0]    Rna = '0;
  logic [4:0]    Rnb = '0;
  logic [3:0]    req_tag = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   Qa, Qb;
  logic [3:0]    rsp_tag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
  } ent_t;
  ent_t model_q[$];

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYPASS_EXP = 32'h22;
  localparam bit          BYPASS_ON  = 1'b1;
`else
  localparam logic [31:0] BYPASS_EXP = 32'h11;
  localparam bit          BYPASS_ON  = 1'b0;
`endif

  regfile_read_port dut (
    .Clk(Clk), .Clrn(Clrn), .Qbus(Qbus), .Wen(Wen), .Wn(Wn), .Wd(Wd),
    .req_valid(req_valid), .req_ready(req_ready), .Rna(Rna), .Rnb(Rnb),
    .req_tag(req_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .Qa(Qa), .Qb(Qb), .rsp_tag(rsp_tag)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] operand(input logic [4:0] rn, input logic [1023:0] qb,
                                          input logic wen, input logic [4:0] wn,
                                          input logic [31:0] wd);
    if (rn == 5'd0) return 32'h0;
    if (BYPASS_ON && wen && wn == rn) return wd;
    return qb[int'(rn)*32 +: 32];
  endfunction

  // Reference model: FIFO of snapshots, depth 2.
  always @(negedge Clrn) model_q.delete();

  always @(posedge Clk) begin
    if (Clrn) begin
      bit acc, pp;
      ent_t e;
      acc = req_valid && (model_q.size() < 2);
      pp  = (model_q.size() > 0) && rsp_ready;
      if (pp) begin
        $display("txn pop  tag=%0d a=%h b=%h", model_q[0].tag, model_q[0].a, model_q[0].b);
        void'(model_q.pop_front());
      end
      if (acc) begin
        e.a   = operand(Rna, Qbus, Wen, Wn, Wd);
        e.b   = operand(Rnb, Qbus, Wen, Wn, Wd);
        e.tag = req_tag;
        model_q.push_back(e);
        $display("txn push tag=%0d a=%h b=%h", e.tag, e.a, e.b);
      end
    end
  end

  always @(negedge Clk) begin
    check("rsp_valid", 32'(rsp_valid), 32'(model_q.size() != 0));
    check("req_ready", 32'(req_ready), 32'(model_q.size() != 2));
    if (model_q.size() != 0) begin
      check("head_qa", Qa, model_q[0].a);
      check("head_qb", Qb, model_q[0].b);
      check("head_tag", 32'(rsp_tag), 32'(model_q[0].tag));
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #1 Clrn = 1'b0;
    step();
    step();
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_qa", Qa, 32'h0);
    check("reset_qb", Qb, 32'h0);
    check("reset_tag", 32'(rsp_tag), 32'h0);
    Clrn = 1'b1;

    // Basic read
    Qbus[5*32 +: 32] = 32'h0000_1234;
    Qbus[9*32 +: 32] = 32'hDEAD_BEEF;
    Rna = 5'd5; Rnb = 5'd9; req_tag = 4'd3; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("read_valid", 32'(rsp_valid), 32'h1);
    check("read_qa", Qa, 32'h0000_1234);
    check("read_qb", Qb, 32'hDEAD_BEEF);
    check("read_tag", 32'(rsp_tag), 32'h3);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    // Register zero
    Qbus[0 +: 32] = 32'hFFFF_FFFF;
    Wen = 1'b1; Wn = 5'd0; Wd = 32'h55;
    Rna = 5'd0; Rnb = 5'd0; req_tag = 4'd4; req_valid = 1'b1;
    step();
    req_valid = 1'b0; Wen = 1'b0;
    check("r0_qa", Qa, 32'h0);
    check("r0_qb", Qb, 32'h0);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    // Same-cycle write to the requested register
    Qbus[7*32 +: 32] = 32'h11;
    Wen = 1'b1; Wn = 5'd7; Wd = 32'h22;
    Rna = 5'd7; Rnb = 5'd5; req_tag = 4'd5; req_valid = 1'b1;
    step();
    req_valid = 1'b0; Wen = 1'b0;
    check("bypass_qa", Qa, BYPASS_EXP);
    check("bypass_qb", Qb, 32'h0000_1234);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    // Backpressure
    Rna = 5'd9; Rnb = 5'd7;
    req_valid = 1'b1; req_tag = 4'd1; step();
    req_tag = 4'd2; step();
    check("bp_full_ready", 32'(req_ready), 32'h0);
    req_tag = 4'd3; step();
    check("bp_held_tag", 32'(rsp_tag), 32'h1);
    check("bp_held_qa", Qa, 32'hDEAD_BEEF);
    rsp_ready = 1'b1; step();
    check("bp_tag2", 32'(rsp_tag), 32'h2);
    step();
    check("bp_tag3", 32'(rsp_tag), 32'h3);
    req_valid = 1'b0; step();
    check("bp_drained", 32'(rsp_valid), 32'h0);

    // Streaming at full rate
    for (int i = 0; i < 8; i++) begin
      Rna = 5'(i + 1); Rnb = 5'(9 - i);
      Qbus[(i+1)*32 +: 32] = 32'h100 + 32'(i);
      req_tag = 4'(i); req_valid = 1'b1;
      step();
      check("stream_ready", 32'(req_ready), 32'h1);
      check("stream_tag", 32'(rsp_tag), 32'(i));
    end
    req_valid = 1'b0; step();
    check("stream_drained", 32'(rsp_valid), 32'h0);

    // Mid-operation reset
    rsp_ready = 1'b0; Rna = 5'd5; Rnb = 5'd9;
    req_valid = 1'b1; req_tag = 4'd6; step();
    req_tag = 4'd7; step();
    req_valid = 1'b0;
    check("mr_full", 32'(req_ready), 32'h0);
    #1 Clrn = 1'b0;
    #1;
    check("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mr_req_ready", 32'(req_ready), 32'h1);
    check("mr_qa", Qa, 32'h0);
    check("mr_tag", 32'(rsp_tag), 32'h0);
    #1 Clrn = 1'b1;
    step();
    check("mr_no_stale", 32'(rsp_valid), 32'h0);
    req_valid = 1'b1; req_tag = 4'd9; step();
    req_valid = 1'b0;
    check("mr_new_tag", 32'(rsp_tag), 32'h9);
    check("mr_new_qa", Qa, 32'h0000_0104);
    rsp_ready = 1'b1; step();
    check("mr_final_empty", 32'(rsp_valid), 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
